game_ctrl_fsm: RTL and testbench

Game-level control engine for Space Invaders. It consumes the enemy alive bitmap and the collision pulses from the ship, ammunition and enemy blocks, and owns the game state (idle / playing / victory / defeat), score, lives and restart pulse. It also selects which live enemy fires next. Its outputs feed the top-level renderer, the ammunition blocks and the HEX display.

---
 rtl/game_ctrl_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_game_ctrl_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm
// Game-level control engine for Space Invaders. Owns the game state,
// BCD score, lives and the restart pulse, and picks which live enemy fires
// next using an LFSR-seeded round-robin scan.
//
// Optional feature macro: HIGH_SCORE_EN adds high_score_bcd, which captures
// the best score on every entry to VICTORY or DEFEAT and survives restart.
//
// Ports:
//   clk             system clock
//   reset           asynchronous active-low reset
//   btn_D           start/fire button (synchronised level)
//   enemy_alive     alive bitmap, bit i = enemy i
//   kill_pulse      player shot hit an enemy (1-cycle)
//   player_hit      enemy shot hit the ship (1-cycle)
//   enemy_at_bottom formation reached the ship row (level)
//   estado_jogo     00 IDLE, 01 PLAYING, 10 VICTORY, 11 DEFEAT
//   restart         1-cycle pulse re-initialising the other game blocks
//   score_bcd       4-digit BCD score, saturates at 9999
//   lives           remaining lives
//   shooter_valid   1-cycle pulse, shooter_id valid
//   shooter_id      index of the firing enemy (held between pulses)
//   high_score_bcd  best score (HIGH_SCORE_EN only)
//
// state   | meaning
// IDLE    | after reset, waiting for a button rise
// PLAYING | game running; score, lives and enemy shots active
// VICTORY | all enemies destroyed; button rise restarts
// DEFEAT  | lives exhausted or formation at bottom; button rise restarts
module game_ctrl_fsm #(
  parameter int unsigned N_ENEMY      = 24,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned SHOT_PERIOD  = 25000000,
  parameter int unsigned PTS_PER_KILL = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_D,
  input  logic [N_ENEMY-1:0] enemy_alive,
  input  logic               kill_pulse,
  input  logic               player_hit,
  input  logic               enemy_at_bottom,
  output logic [1:0]         estado_jogo,
  output logic               restart,
  output logic [15:0]        score_bcd,
  output logic [1:0]         lives,
  output logic               shooter_valid,
  output logic [4:0]         shooter_id
`ifdef HIGH_SCORE_EN
  ,
  output logic [15:0]        high_score_bcd
`endif
);

  localparam int TW = (SHOT_PERIOD > 1) ? $clog2(SHOT_PERIOD) : 1;
  localparam logic [3:0] PTS_ONES = 4'(PTS_PER_KILL % 10);
  localparam logic [3:0] PTS_TENS = 4'((PTS_PER_KILL / 10) % 10);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAYING = 2'b01,
    S_VICTORY = 2'b10,
    S_DEFEAT  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic            btn_q;
  logic [7:0]      lfsr_q;
  logic            lfsr_fb;
  logic [TW-1:0]   timer_q;
  logic            timer_wrap;
  logic [2:0]      mask_q;
  logic            scan_active;
  logic [4:0]      scan_idx;
  logic [4:0]      scan_cnt;
  logic [4:0]      scan_idx_next;
  logic [4:0]      start_idx;
  logic [31:0]     alive_pad;
  logic            rise;
  logic            start_game;
  logic            playing;
  logic [15:0]     score_d;
  logic [1:0]      lives_d;

  // Adds PTS_PER_KILL digit by digit; a carry out of the thousands digit
  // means the true sum exceeds 9999, so the score pins at 9999.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a);
    logic [15:0] sum;
    logic [4:0]  d;
    logic [3:0]  addend;
    logic        carry;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addend = (i == 0) ? PTS_ONES : (i == 1) ? PTS_TENS : 4'd0;
      d = {1'b0, a[4*i +: 4]} + {1'b0, addend} + {4'd0, carry};
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    return carry ? 16'h9999 : sum;
  endfunction

  assign rise        = btn_D & ~btn_q;
  assign playing     = (state_q == S_PLAYING);
  assign start_game  = ~playing & rise;
  assign estado_jogo = state_q;
  assign lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign timer_wrap  = (timer_q == TW'(SHOT_PERIOD - 1));
  assign alive_pad   = 32'(enemy_alive);

  // Fold the 5-bit LFSR slice into 0..N_ENEMY-1 with one subtraction.
  always_comb begin
    start_idx = lfsr_q[4:0];
    if ({1'b0, lfsr_q[4:0]} >= 6'(N_ENEMY))
      start_idx = 5'({1'b0, lfsr_q[4:0]} - 6'(N_ENEMY));
  end

  assign scan_idx_next = (scan_idx == 5'(N_ENEMY - 1)) ? 5'd0 : scan_idx + 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    score_d = score_bcd;
    lives_d = lives;
    case (state_q)
      S_PLAYING: begin
        if (kill_pulse) score_d = bcd_add_sat(score_bcd);
        if (player_hit && lives != 2'd0) lives_d = lives - 2'd1;
        // Defeat is checked first so it wins over a simultaneous victory.
        if (enemy_at_bottom || (player_hit && lives == 2'd1))
          state_d = S_DEFEAT;
        else if (enemy_alive == '0 && mask_q == 3'd0)
          state_d = S_VICTORY;
      end
      default: begin
        if (rise) begin
          state_d = S_PLAYING;
          score_d = '0;
          lives_d = 2'(LIVES_INIT);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q         <= 1'b0;
      lfsr_q        <= 8'hA5;
      restart       <= 1'b0;
      score_bcd     <= '0;
      lives         <= 2'(LIVES_INIT);
      timer_q       <= '0;
      mask_q        <= '0;
      scan_active   <= 1'b0;
      scan_idx      <= '0;
      scan_cnt      <= '0;
      shooter_valid <= 1'b0;
      shooter_id    <= '0;
    end else begin
      btn_q         <= btn_D;
      lfsr_q        <= {lfsr_q[6:0], lfsr_fb};
      restart       <= start_game;
      score_bcd     <= score_d;
      lives         <= lives_d;
      shooter_valid <= 1'b0;
      if (start_game) begin
        timer_q     <= '0;
        // Hold off the victory check while enemy blocks reload their bitmap.
        mask_q      <= 3'd4;
        scan_active <= 1'b0;
      end else if (playing) begin
        if (mask_q != 3'd0) mask_q <= mask_q - 3'd1;
        timer_q <= timer_wrap ? '0 : timer_q + TW'(1);
        if (state_d != S_PLAYING) begin
          scan_active <= 1'b0;
        end else if (scan_active) begin
          // A wrap arriving here is dropped: the running scan owns the slot.
          if (alive_pad[scan_idx]) begin
            shooter_valid <= 1'b1;
            shooter_id    <= scan_idx;
            scan_active   <= 1'b0;
          end else if (scan_cnt == 5'(N_ENEMY - 1)) begin
            scan_active <= 1'b0;
          end else begin
            scan_idx <= scan_idx_next;
            scan_cnt <= scan_cnt + 5'd1;
          end
        end else if (timer_wrap) begin
          scan_active <= 1'b1;
          scan_idx    <= start_idx;
          scan_cnt    <= '0;
        end
      end else begin
        scan_active <= 1'b0;
      end
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      high_score_bcd <= '0;
    else if (playing && state_d != S_PLAYING && score_d > high_score_bcd)
      // Valid BCD orders the same as plain binary, so a direct compare works.
      high_score_bcd <= score_d;
  end
`endif

endmodule

// File: tb/tb_game_ctrl_fsm.sv
module tb_game_ctrl_fsm;
  localparam int N_ENEMY = 24;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               btn_D = 1'b0;
  logic [N_ENEMY-1:0] enemy_alive = '1;
  logic               kill_pulse = 1'b0;
  logic               player_hit = 1'b0;
  logic               enemy_at_bottom = 1'b0;
  logic [1:0]         estado_jogo;
  logic               restart;
  logic [15:0]        score_bcd;
  logic [1:0]         lives;
  logic               shooter_valid;
  logic [4:0]         shooter_id;
`ifdef HIGH_SCORE_EN
  logic [15:0]        high_score_bcd;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [7:0] lfsr_m;

  always #5 clk = ~clk;

  game_ctrl_fsm #(
    .N_ENEMY(N_ENEMY), .LIVES_INIT(3), .SHOT_PERIOD(16), .PTS_PER_KILL(10)
  ) dut (
    .clk(clk), .reset(reset), .btn_D(btn_D), .enemy_alive(enemy_alive),
    .kill_pulse(kill_pulse), .player_hit(player_hit),
    .enemy_at_bottom(enemy_at_bottom), .estado_jogo(estado_jogo),
    .restart(restart), .score_bcd(score_bcd), .lives(lives),
    .shooter_valid(shooter_valid), .shooter_id(shooter_id)
`ifdef HIGH_SCORE_EN
    , .high_score_bcd(high_score_bcd)
`endif
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int idx_of(input logic [7:0] v);
    int i;
    i = int'(v[4:0]);
    if (i >= N_ENEMY) i -= N_ENEMY;
    return i;
  endfunction

  // Reference LFSR: starts at A5 on reset and advances every clock.
  always @(posedge clk or negedge reset)
    if (!reset) lfsr_m <= 8'hA5;
    else        lfsr_m <= lfsr_step(lfsr_m);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int rs_seen;
    int sv_seen;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (estado_jogo !== 2'b00) begin errors++; $display("FAIL rst_state: got %b expected 00", estado_jogo); end
    vectors++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_score: got %h expected 0000", score_bcd); end
    vectors++; if (lives !== 2'd3) begin errors++; $display("FAIL rst_lives: got %0d expected 3", lives); end
    vectors++; if (restart !== 1'b0 || shooter_valid !== 1'b0) begin errors++; $display("FAIL rst_pulses: got restart=%b sv=%b expected 0 0", restart, shooter_valid); end
    vectors++; if (shooter_id !== 5'd0) begin errors++; $display("FAIL rst_id: got %0d expected 0", shooter_id); end
    reset = 1'b1;
    rs_seen = 0;
    sv_seen = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (restart === 1'b1) rs_seen++;
      if (shooter_valid === 1'b1) sv_seen++;
    end
    vectors++; if (estado_jogo !== 2'b00) begin errors++; $display("FAIL idle_state: got %b expected 00", estado_jogo); end
    vectors++; if (score_bcd !== 16'h0000 || lives !== 2'd3) begin errors++; $display("FAIL idle_regs: got score=%h lives=%0d expected 0000 3", score_bcd, lives); end
    vectors++; if (rs_seen != 0 || sv_seen != 0) begin errors++; $display("FAIL idle_pulses: got restart=%0d sv=%0d expected 0 0", rs_seen, sv_seen); end
  endtask

  task automatic test_start;
    int rs_seen;
    btn_D = 1'b1;
    tick();
    vectors++; if (estado_jogo !== 2'b01) begin errors++; $display("FAIL start_state: got %b expected 01", estado_jogo); end
    vectors++; if (restart !== 1'b1) begin errors++; $display("FAIL start_restart: got %b expected 1", restart); end
    vectors++; if (score_bcd !== 16'h0000 || lives !== 2'd3) begin errors++; $display("FAIL start_regs: got score=%h lives=%0d expected 0000 3", score_bcd, lives); end
    rs_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (restart === 1'b1) rs_seen++;
    end
    // Rise while PLAYING is a fire command and must not restart the game.
    btn_D = 1'b0;
    tick();
    if (restart === 1'b1) rs_seen++;
    btn_D = 1'b1;
    tick();
    if (restart === 1'b1) rs_seen++;
    tick();
    if (restart === 1'b1) rs_seen++;
    btn_D = 1'b0;
    vectors++; if (rs_seen != 0) begin errors++; $display("FAIL start_single_pulse: got %0d extra pulses expected 0", rs_seen); end
    vectors++; if (estado_jogo !== 2'b01) begin errors++; $display("FAIL start_hold: got %b expected 01", estado_jogo); end
  endtask

  task automatic test_score;
    kill_pulse = 1'b1;
    repeat (99) tick();
    vectors++; if (score_bcd !== 16'h0990) begin errors++; $display("FAIL score_990: got %h expected 0990", score_bcd); end
    tick();
    vectors++; if (score_bcd !== 16'h1000) begin errors++; $display("FAIL score_carry: got %h expected 1000", score_bcd); end
    repeat (899) tick();
    vectors++; if (score_bcd !== 16'h9990) begin errors++; $display("FAIL score_9990: got %h expected 9990", score_bcd); end
    tick();
    vectors++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL score_sat: got %h expected 9999", score_bcd); end
    tick();
    kill_pulse = 1'b0;
    vectors++; if (score_bcd !== 16'h9999) begin errors++; $display("FAIL score_sat_hold: got %h expected 9999", score_bcd); end
    vectors++; if (lives !== 2'd3 || estado_jogo !== 2'b01) begin errors++; $display("FAIL score_side: got lives=%0d state=%b expected 3 01", lives, estado_jogo); end
  endtask

  task automatic test_lives;
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    vectors++; if (lives !== 2'd2 || estado_jogo !== 2'b01) begin errors++; $display("FAIL hit1: got lives=%0d state=%b expected 2 01", lives, estado_jogo); end
    tick();
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    vectors++; if (lives !== 2'd1 || estado_jogo !== 2'b01) begin errors++; $display("FAIL hit2: got lives=%0d state=%b expected 1 01", lives, estado_jogo); end
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    vectors++; if (lives !== 2'd0 || estado_jogo !== 2'b11) begin errors++; $display("FAIL hit3: got lives=%0d state=%b expected 0 11", lives, estado_jogo); end
    player_hit = 1'b1; kill_pulse = 1'b1; tick(); player_hit = 1'b0; kill_pulse = 1'b0;
    tick();
    vectors++; if (lives !== 2'd0 || estado_jogo !== 2'b11 || score_bcd !== 16'h9999) begin errors++; $display("FAIL defeat_ignore: got lives=%0d state=%b score=%h expected 0 11 9999", lives, estado_jogo, score_bcd); end
  endtask

  task automatic test_conflict;
    btn_D = 1'b1; tick(); btn_D = 1'b0;
    vectors++; if (estado_jogo !== 2'b01 || restart !== 1'b1 || score_bcd !== 16'h0000 || lives !== 2'd3) begin errors++; $display("FAIL restart_from_defeat: got state=%b restart=%b score=%h lives=%0d expected 01 1 0000 3", estado_jogo, restart, score_bcd, lives); end
    kill_pulse = 1'b1; player_hit = 1'b1; tick(); kill_pulse = 1'b0; player_hit = 1'b0;
    vectors++; if (score_bcd !== 16'h0010 || lives !== 2'd2) begin errors++; $display("FAIL kill_and_hit: got score=%h lives=%0d expected 0010 2", score_bcd, lives); end
    repeat (4) tick();
    enemy_alive = '0; enemy_at_bottom = 1'b1;
    tick();
    vectors++; if (estado_jogo !== 2'b11) begin errors++; $display("FAIL defeat_priority: got %b expected 11", estado_jogo); end
    enemy_alive = '1; enemy_at_bottom = 1'b0;
    tick();
    btn_D = 1'b1; tick(); btn_D = 1'b0;
    vectors++; if (estado_jogo !== 2'b01 || restart !== 1'b1 || score_bcd !== 16'h0000 || lives !== 2'd3) begin errors++; $display("FAIL replay: got state=%b restart=%b score=%h lives=%0d expected 01 1 0000 3", estado_jogo, restart, score_bcd, lives); end
  endtask

  task automatic test_victory_mask;
    int early;
    enemy_at_bottom = 1'b1; tick(); enemy_at_bottom = 1'b0;
    enemy_alive = '0;
    tick();
    btn_D = 1'b1; tick(); btn_D = 1'b0;
    vectors++; if (estado_jogo !== 2'b01) begin errors++; $display("FAIL mask_start: got %b expected 01", estado_jogo); end
    early = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (estado_jogo !== 2'b01 || shooter_valid !== 1'b0) early++;
    end
    vectors++; if (early != 0) begin errors++; $display("FAIL mask_hold: got %0d early exits expected 0", early); end
    tick();
    vectors++; if (estado_jogo !== 2'b10) begin errors++; $display("FAIL victory: got %b expected 10", estado_jogo); end
    vectors++; if (shooter_valid !== 1'b0) begin errors++; $display("FAIL victory_no_shot: got %b expected 0", shooter_valid); end
  endtask

  task automatic test_shot;
    logic [7:0] ahead;
    int found;
    int first_k;
    int pulses;
    int s;
    logic [4:0] first_id;
    enemy_alive = 24'h000020;
    found = 0;
    // Press so that the LFSR value seen at the first timer wrap gives index 7.
    for (int n = 0; n < 600 && found == 0; n++) begin
      ahead = lfsr_m;
      repeat (16) ahead = lfsr_step(ahead);
      if (idx_of(ahead) == 7) found = 1;
      else tick();
    end
    vectors++; if (found == 0) begin errors++; $display("FAIL shot_seed_search: got no index 7 expected one within 600 cycles"); end
    btn_D = 1'b1; tick(); btn_D = 1'b0;
    vectors++; if (estado_jogo !== 2'b01 || restart !== 1'b1) begin errors++; $display("FAIL shot_start: got state=%b restart=%b expected 01 1", estado_jogo, restart); end
    first_k = -1; first_id = '0; pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (shooter_valid === 1'b1) begin
        pulses++;
        if (first_k < 0) begin first_k = k; first_id = shooter_id; end
      end
    end
    // Wrap at edge 16, idx 7..23 then 0..5 = 23 scan cycles -> pulse at edge 39.
    vectors++; if (first_k != 39) begin errors++; $display("FAIL shot_latency: got edge %0d expected 39", first_k); end
    vectors++; if (first_id !== 5'd5) begin errors++; $display("FAIL shot_id: got %0d expected 5", first_id); end
    vectors++; if (pulses != 1) begin errors++; $display("FAIL shot_count: got %0d expected 1", pulses); end
    vectors++; if (shooter_id !== 5'd5) begin errors++; $display("FAIL shot_id_hold: got %0d expected 5", shooter_id); end
    // Next wrap at edge 48 uses the LFSR value after edge 47; place the only
    // live enemy 10 slots ahead so the pulse would land at edge 59.
    ahead = lfsr_step(lfsr_step(lfsr_m));
    s = idx_of(ahead);
    enemy_alive = '0;
    enemy_alive[(s + 10) % N_ENEMY] = 1'b1;
    pulses = 0;
    repeat (4) begin tick(); if (shooter_valid === 1'b1) pulses++; end
    enemy_at_bottom = 1'b1; tick(); enemy_at_bottom = 1'b0;
    if (shooter_valid === 1'b1) pulses++;
    vectors++; if (estado_jogo !== 2'b11) begin errors++; $display("FAIL abort_defeat: got %b expected 11", estado_jogo); end
    repeat (20) begin tick(); if (shooter_valid === 1'b1) pulses++; end
    vectors++; if (pulses != 0) begin errors++; $display("FAIL abort_no_pulse: got %0d pulses expected 0", pulses); end
    enemy_alive = '1;
  endtask

  task automatic test_reset_mid;
    btn_D = 1'b1; tick(); btn_D = 1'b0;
    kill_pulse = 1'b1; tick(); kill_pulse = 1'b0;
    player_hit = 1'b1; tick(); player_hit = 1'b0;
    vectors++; if (score_bcd !== 16'h0010 || lives !== 2'd2) begin errors++; $display("FAIL mid_pre: got score=%h lives=%0d expected 0010 2", score_bcd, lives); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (estado_jogo !== 2'b00 || score_bcd !== 16'h0000 || lives !== 2'd3) begin errors++; $display("FAIL mid_async: got state=%b score=%h lives=%0d expected 00 0000 3", estado_jogo, score_bcd, lives); end
    vectors++; if (shooter_id !== 5'd0 || shooter_valid !== 1'b0 || restart !== 1'b0) begin errors++; $display("FAIL mid_async_out: got id=%0d sv=%b restart=%b expected 0 0 0", shooter_id, shooter_valid, restart); end
    tick();
    reset = 1'b1;
    tick(); tick();
    vectors++; if (estado_jogo !== 2'b00 || score_bcd !== 16'h0000 || lives !== 2'd3 || restart !== 1'b0) begin errors++; $display("FAIL mid_release: got state=%b score=%h lives=%0d restart=%b expected 00 0000 3 0", estado_jogo, score_bcd, lives, restart); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_score();
    test_lives();
    test_conflict();
    test_victory_mask();
    test_shot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
